// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback definitions: fixed register roles and the queued write record.
package jay_pkg;
   localparam int WB_DW = 8;
   localparam int WB_AW = 3;

   localparam int REG_ZERO = 0;
   localparam int REG_ONE  = 1;
   localparam int REG_LD   = 2;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] dat;
   } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Execute/memory-side bus of the register-file writeback arbiter.
interface rf_wb_arbiter_if #(parameter int DW = 8, parameter int AW = 3);
   logic          alu_wr_req;
   logic [AW-1:0] alu_wr_addr;
   logic [DW-1:0] alu_wr_dat;
   logic          alu_stall;
   logic          ld_issue;
   logic          ld_valid;
   logic [DW-1:0] ld_dat;
   logic          ld_busy;
   logic [AW-1:0] rd_addrA;
   logic [AW-1:0] rd_addrB;
   logic          hazard;
   logic          wr_en;
   logic          MemtoReg;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] dat_out;
   logic          proto_err;

   modport slave (
      input  alu_wr_req, alu_wr_addr, alu_wr_dat, ld_issue, ld_valid, ld_dat,
             rd_addrA, rd_addrB,
      output alu_stall, ld_busy, hazard, wr_en, MemtoReg, wr_addr, dat_out, proto_err
   );

   modport master (
      output alu_wr_req, alu_wr_addr, alu_wr_dat, ld_issue, ld_valid, ld_dat,
             rd_addrA, rd_addrB,
      input  alu_stall, ld_busy, hazard, wr_en, MemtoReg, wr_addr, dat_out, proto_err
   );
endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Shift-style FIFO of pending ALU writes; entry 0 is always the head, which keeps
// the per-entry valid taps a simple index-vs-count compare.
module rf_wb_arbiter_fifo import jay_pkg::*; #(
   parameter int QD = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  wb_req_t                     din,
   output wb_req_t                     head,
   output logic                        full,
   output logic                        empty,
   output logic [QD-1:0]               ent_vld,
   output logic [QD-1:0][WB_AW-1:0]    ent_addr
);
   localparam int CW = $clog2(QD + 1);

   wb_req_t       mem [QD];
   logic [CW-1:0] count;
   logic [CW-1:0] widx;

   assign widx  = pop ? count - CW'(1) : count;
   assign head  = mem[0];
   assign full  = (count == CW'(QD));
   assign empty = (count == '0);

   always_comb begin
      for (int i = 0; i < QD; i++) begin
         ent_vld[i]  = (CW'(i) < count);
         ent_addr[i] = mem[i].addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= count + CW'(push) - CW'(pop);
   end

   // A push landing on the slot vacated by a simultaneous pop takes precedence.
   always_ff @(posedge clk) begin
      for (int i = 0; i < QD; i++) begin
         if (push && (CW'(i) == widx)) mem[i] <= din;
         else if (pop && (i < QD - 1)) mem[i] <= mem[(i + 1) % QD];
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: load returns beat queued ALU writes, which beat
// a fresh ALU bypass; also tracks pending writes so decode can stall on hazards.
module rf_wb_arbiter import jay_pkg::*; #(
   parameter int DW = 8,
   parameter int AW = 3,
   parameter int QD = 2
) (
   input logic             clk,
   input logic             reset,
   rf_wb_arbiter_if.slave  bus
);
   localparam logic [AW-1:0] LD_ADDR  = AW'(REG_LD);
   localparam logic [AW-1:0] ONE_ADDR = AW'(REG_ONE);

   wb_req_t              head, din;
   logic                 full, empty;
   logic [QD-1:0]        ent_vld;
   logic [QD-1:0][AW-1:0] ent_addr;

   logic          load_win, alu_const, alu_acc, bypass, push, pop;
   logic          hit_a, hit_b;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_dat;

   assign din = '{addr: bus.alu_wr_addr, dat: bus.alu_wr_dat};

   rf_wb_arbiter_fifo #(.QD(QD)) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .push     (push),
      .pop      (pop),
      .din      (din),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .ent_vld  (ent_vld),
      .ent_addr (ent_addr)
   );

   // The r2 stall term keeps an ALU write to r2 behind an in-flight load.
   always_comb begin
      load_win      = bus.ld_valid & bus.ld_busy;
      alu_const     = (bus.alu_wr_addr <= ONE_ADDR);
      bus.alu_stall = bus.alu_wr_req & (full | ((bus.alu_wr_addr == LD_ADDR) & bus.ld_busy));
      alu_acc       = bus.alu_wr_req & ~bus.alu_stall;
      pop           = ~load_win & ~empty;
      bypass        = alu_acc & ~alu_const & empty & ~load_win;
      push          = alu_acc & ~alu_const & ~bypass;
   end

   always_comb begin
      win_addr = bus.wr_addr;
      win_dat  = bus.dat_out;
      if (load_win) begin
         win_addr = LD_ADDR;
         win_dat  = bus.ld_dat;
      end else if (pop) begin
         win_addr = head.addr;
         win_dat  = head.dat;
      end else if (bypass) begin
         win_addr = bus.alu_wr_addr;
         win_dat  = bus.alu_wr_dat;
      end
   end

   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < QD; i++) begin
         if (ent_vld[i]) begin
            hit_a = hit_a | (ent_addr[i] == bus.rd_addrA);
            hit_b = hit_b | (ent_addr[i] == bus.rd_addrB);
         end
      end
      if (bus.wr_en | bus.MemtoReg) begin
         hit_a = hit_a | (bus.wr_addr == bus.rd_addrA);
         hit_b = hit_b | (bus.wr_addr == bus.rd_addrB);
      end
      if (bus.ld_busy) begin
         hit_a = hit_a | (bus.rd_addrA == LD_ADDR);
         hit_b = hit_b | (bus.rd_addrB == LD_ADDR);
      end
      bus.hazard = (hit_a & (bus.rd_addrA > ONE_ADDR)) | (hit_b & (bus.rd_addrB > ONE_ADDR));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wr_en     <= 1'b0;
         bus.MemtoReg  <= 1'b0;
         bus.wr_addr   <= '0;
         bus.dat_out   <= '0;
         bus.ld_busy   <= 1'b0;
         bus.proto_err <= 1'b0;
      end else begin
         bus.wr_en    <= pop | bypass;
         bus.MemtoReg <= load_win;
         bus.wr_addr  <= win_addr;
         bus.dat_out  <= win_dat;
         // A return completing alongside a second issue still frees the slot.
         if (load_win)         bus.ld_busy <= 1'b0;
         else if (bus.ld_issue) bus.ld_busy <= 1'b1;
         if ((bus.ld_issue & bus.ld_busy) | (bus.ld_valid & ~bus.ld_busy))
            bus.proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a
// queue-based model of the writeback rules.
module tb_rf_wb_arbiter;
   localparam int QD = 2;

   typedef struct {
      logic [2:0] a;
      logic [7:0] d;
   } ent_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   rf_wb_arbiter_if #(.DW(8), .AW(3)) bus ();

   rf_wb_arbiter #(.DW(8), .AW(3), .QD(QD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: what the registered outputs should hold now.
   ent_t       q[$];
   logic       m_wr_en, m_m2r, m_busy, m_perr;
   logic [2:0] m_addr;
   logic [7:0] m_dat;

   function automatic logic exp_stall();
      return bus.alu_wr_req && ((q.size() == QD) || (bus.alu_wr_addr == 3'd2 && m_busy));
   endfunction

   function automatic logic exp_hz(input logic [2:0] a);
      logic h;
      if (a < 3'd2) return 1'b0;
      h = (a == 3'd2 && m_busy) || ((m_wr_en || m_m2r) && m_addr == a);
      foreach (q[i]) if (q[i].a == a) h = 1'b1;
      return h;
   endfunction

   task automatic tick();
      logic win, acc, cst, byp;
      ent_t e;
      win = 1'b0; acc = 1'b0; cst = 1'b0; byp = 1'b0;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_wr_en = 1'b0; m_m2r = 1'b0; m_busy = 1'b0; m_perr = 1'b0;
         m_addr = 3'd0; m_dat = 8'd0;
      end else begin
         win = bus.ld_valid && m_busy;
         acc = bus.alu_wr_req && !exp_stall();
         cst = bus.alu_wr_addr < 3'd2;
         if (win) begin
            m_wr_en = 1'b0; m_m2r = 1'b1; m_addr = 3'd2; m_dat = bus.ld_dat;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            m_wr_en = 1'b1; m_m2r = 1'b0; m_addr = e.a; m_dat = e.d;
         end else if (acc && !cst) begin
            m_wr_en = 1'b1; m_m2r = 1'b0; m_addr = bus.alu_wr_addr; m_dat = bus.alu_wr_dat;
            byp = 1'b1;
         end else begin
            m_wr_en = 1'b0; m_m2r = 1'b0;
         end
         if (acc && !cst && !byp) begin
            e.a = bus.alu_wr_addr; e.d = bus.alu_wr_dat;
            q.push_back(e);
         end
         if ((bus.ld_issue && m_busy) || (bus.ld_valid && !m_busy)) m_perr = 1'b1;
         if (win) m_busy = 1'b0;
         else if (bus.ld_issue) m_busy = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_wr_req = 1'b0; bus.alu_wr_addr = 3'd0; bus.alu_wr_dat = 8'd0;
      bus.ld_issue = 1'b0; bus.ld_valid = 1'b0; bus.ld_dat = 8'd0;
      bus.rd_addrA = 3'd0; bus.rd_addrB = 3'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.ld_issue = 1'b1; tick(); bus.ld_issue = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_dat = 8'h5A;
      bus.alu_wr_req = 1'b1; bus.alu_wr_addr = 3'd6; bus.alu_wr_dat = 8'h66;
      tick();
      idle_inputs();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      bus.rd_addrA = 3'd2; bus.rd_addrB = 3'd6;
      bus.alu_wr_req = 1'b1; bus.alu_wr_addr = 3'd2;
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out, bus.ld_busy, bus.proto_err} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%0b m2r=%0b addr=%0d dat=%0h busy=%0b perr=%0b expected all 0",
                  bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out, bus.ld_busy, bus.proto_err);
      end
      checks++;
      if (bus.hazard !== 1'b0 || bus.alu_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_hazard_stall: got hazard=%0b stall=%0b expected 0 0", bus.hazard, bus.alu_stall);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_alu_basic();
      idle_inputs();
      bus.alu_wr_req = 1'b1; bus.alu_wr_addr = 3'd5; bus.alu_wr_dat = 8'hA5;
      @(negedge clk);
      checks++;
      if (bus.alu_stall !== 1'b0) begin
         errors++; $display("FAIL alu_basic_stall: got %0b expected 0", bus.alu_stall);
      end
      tick();
      idle_inputs();
      bus.rd_addrA = 3'd5;
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out} !== {1'b1, 1'b0, 3'd5, 8'hA5}) begin
         errors++;
         $display("FAIL alu_basic_write: got en=%0b m2r=%0b addr=%0d dat=%0h expected 1 0 5 a5",
                  bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out);
      end
      checks++;
      if (bus.hazard !== 1'b1) begin
         errors++; $display("FAIL alu_basic_hazard: got %0b expected 1", bus.hazard);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.hazard !== 1'b0 || bus.wr_en !== 1'b0) begin
         errors++; $display("FAIL alu_basic_drain: got hazard=%0b en=%0b expected 0 0", bus.hazard, bus.wr_en);
      end
   endtask

   task automatic test_load_priority();
      int   saw_stall = 0;
      int   loads_seen = 0;
      logic [7:0] d = 8'h40;
      idle_inputs();
      bus.alu_wr_req = 1'b1; bus.alu_wr_addr = 3'd4;
      for (int c = 0; c < 10; c++) begin
         bus.alu_wr_dat = d;
         bus.ld_issue = (c == 0 || c == 4);
         bus.ld_valid = (c == 3 || c == 7);
         bus.ld_dat   = (c == 3) ? 8'h3C : 8'hC3;
         @(negedge clk);
         checks++;
         if (bus.alu_stall !== exp_stall() || (c == 8 && bus.alu_stall !== 1'b1)) begin
            errors++; $display("FAIL load_prio_stall c=%0d: got %0b expected %0b", c, bus.alu_stall, exp_stall());
         end
         if (bus.alu_stall === 1'b1) saw_stall++;
         if (!exp_stall()) d = d + 8'd1;
         tick();
         checks++;
         if ({bus.wr_en, bus.MemtoReg} !== {m_wr_en, m_m2r} ||
             ((m_wr_en || m_m2r) && {bus.wr_addr, bus.dat_out} !== {m_addr, m_dat})) begin
            errors++;
            $display("FAIL load_prio_order c=%0d: got en=%0b m2r=%0b addr=%0d dat=%0h expected %0b %0b %0d %0h",
                     c, bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out, m_wr_en, m_m2r, m_addr, m_dat);
         end
         if (c == 3) begin
            checks++;
            if ({bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out} !== {1'b0, 1'b1, 3'd2, 8'h3C}) begin
               errors++;
               $display("FAIL load_prio_win: got en=%0b m2r=%0b addr=%0d dat=%0h expected 0 1 2 3c",
                        bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out);
            end
         end
         if (bus.MemtoReg === 1'b1) loads_seen++;
      end
      checks++;
      if (saw_stall != 1 || loads_seen != 2) begin
         errors++; $display("FAIL load_prio_full: got stalls=%0d loads=%0d expected 1 2", saw_stall, loads_seen);
      end
      idle_inputs();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_r2_waw();
      logic accepted = 1'b0;
      idle_inputs();
      for (int c = 0; c < 7; c++) begin
         bus.ld_issue = (c == 0);
         bus.ld_valid = (c == 3);
         bus.ld_dat   = 8'h11;
         bus.alu_wr_req = (c >= 1) && !accepted;
         bus.alu_wr_addr = 3'd2; bus.alu_wr_dat = 8'h77;
         @(negedge clk);
         checks++;
         if (bus.alu_stall !== ((c >= 1) && (c <= 3))) begin
            errors++; $display("FAIL r2_waw_stall c=%0d: got %0b expected %0b", c, bus.alu_stall, (c >= 1) && (c <= 3));
         end
         if (bus.alu_wr_req && !exp_stall()) accepted = 1'b1;
         tick();
         if (c == 3 || c == 4) begin
            checks++;
            if ({bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out} !==
                ((c == 3) ? {1'b0, 1'b1, 3'd2, 8'h11} : {1'b1, 1'b0, 3'd2, 8'h77})) begin
               errors++;
               $display("FAIL r2_waw_order c=%0d: got en=%0b m2r=%0b addr=%0d dat=%0h", c,
                        bus.wr_en, bus.MemtoReg, bus.wr_addr, bus.dat_out);
            end
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_const_regs();
      idle_inputs();
      for (int r = 0; r < 2; r++) begin
         bus.alu_wr_req = 1'b1; bus.alu_wr_addr = 3'(r); bus.alu_wr_dat = 8'hFF;
         bus.rd_addrA = 3'd0; bus.rd_addrB = 3'd1;
         @(negedge clk);
         checks++;
         if (bus.alu_stall !== 1'b0) begin
            errors++; $display("FAIL const_stall r%0d: got %0b expected 0", r, bus.alu_stall);
         end
         tick();
         bus.alu_wr_req = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.wr_en !== 1'b0 || bus.hazard !== 1'b0) begin
            errors++; $display("FAIL const_write r%0d: got en=%0b hazard=%0b expected 0 0", r, bus.wr_en, bus.hazard);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_proto_err();
      idle_inputs();
      bus.ld_valid = 1'b1; bus.ld_dat = 8'hEE;
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.proto_err, bus.MemtoReg, bus.wr_en} !== 3'b100) begin
         errors++;
         $display("FAIL perr_stray_valid: got perr=%0b m2r=%0b en=%0b expected 1 0 0",
                  bus.proto_err, bus.MemtoReg, bus.wr_en);
      end
      for (int c = 0; c < 3; c++) tick();
      @(negedge clk);
      checks++;
      if (bus.proto_err !== 1'b1) begin
         errors++; $display("FAIL perr_sticky: got %0b expected 1", bus.proto_err);
      end
      reset = 1'b1; tick(); reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.proto_err !== 1'b0) begin
         errors++; $display("FAIL perr_reset: got %0b expected 0", bus.proto_err);
      end
      bus.ld_issue = 1'b1; tick(); tick(); bus.ld_issue = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.proto_err !== 1'b1 || bus.ld_busy !== 1'b1) begin
         errors++; $display("FAIL perr_double_issue: got perr=%0b busy=%0b expected 1 1", bus.proto_err, bus.ld_busy);
      end
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic test_random();
      logic hold = 1'b0;
      logic [5:0] got, exp;
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            bus.alu_wr_req  = ($urandom_range(0, 2) != 0);
            bus.alu_wr_addr = 3'($urandom_range(0, 7));
            bus.alu_wr_dat  = 8'($urandom);
         end
         bus.ld_issue = !m_busy && ($urandom_range(0, 5) == 0);
         bus.ld_valid = m_busy && ($urandom_range(0, 2) == 0);
         bus.ld_dat   = 8'($urandom);
         bus.rd_addrA = 3'($urandom_range(0, 7));
         bus.rd_addrB = 3'($urandom_range(0, 7));
         @(negedge clk);
         got = {bus.alu_stall, bus.hazard, bus.wr_en, bus.MemtoReg, bus.ld_busy, bus.proto_err};
         exp = {exp_stall(), exp_hz(bus.rd_addrA) | exp_hz(bus.rd_addrB), m_wr_en, m_m2r, m_busy, m_perr};
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL random_ctrl c=%0d: got %b expected %b", c, got, exp);
         end
         if (m_wr_en || m_m2r) begin
            checks++;
            if ({bus.wr_addr, bus.dat_out} !== {m_addr, m_dat}) begin
               errors++;
               $display("FAIL random_data c=%0d: got addr=%0d dat=%0h expected addr=%0d dat=%0h",
                        c, bus.wr_addr, bus.dat_out, m_addr, m_dat);
            end
         end
         hold = exp_stall();
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      test_reset();
      test_alu_basic();
      test_load_priority();
      test_r2_waw();
      test_const_regs();
      test_proto_err();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
